// File: rtl/zx_pkg.sv
// Shared constants and helpers for the ZX Spectrum memory paging blocks:
// port addresses, fixed bank numbers, port decoders and the +3 special-map table.
package zx_pkg;

    localparam logic [15:0] PORT_7FFD = 16'h7FFD;
    localparam logic [15:0] PORT_1FFD = 16'h1FFD;
    localparam logic [15:0] PORT_FE   = 16'h00FE;

    localparam logic [2:0] BANK_SCREEN = 3'd5;
    localparam logic [2:0] BANK_FIXED  = 3'd2;

    typedef enum logic [1:0] {
        MAP_0123 = 2'b00,
        MAP_4567 = 2'b01,
        MAP_4563 = 2'b10,
        MAP_4763 = 2'b11
    } special_map_t;

    function automatic logic is_port_7ffd(input logic [15:0] a, input logic full);
        return full ? (a == PORT_7FFD) : (!a[15] && !a[1]);
    endfunction

    function automatic logic is_port_1ffd(input logic [15:0] a, input logic full);
        return full ? (a == PORT_1FFD) : ((a[15:12] == PORT_1FFD[15:12]) && !a[1]);
    endfunction

    // The ULA port only ever looks at A0, whatever the decode mode.
    function automatic logic is_port_fe(input logic [15:0] a);
        return a[0] == PORT_FE[0];
    endfunction

    // Bank placed in each 16K slot when the +3 all-RAM mode is active.
    function automatic logic [2:0] special_bank(input special_map_t map, input logic [1:0] slot);
        case (map)
            MAP_0123: return {1'b0, slot};
            MAP_4567: return {1'b1, slot};
            MAP_4563: return (slot == 2'd3) ? 3'd3 : {1'b1, slot};
            default: begin
                case (slot)
                    2'd0:    return 3'd4;
                    2'd1:    return 3'd7;
                    2'd2:    return 3'd6;
                    default: return 3'd3;
                endcase
            end
        endcase
    endfunction

endpackage

// File: rtl/zx_bank_mapper_if.sv
// CPU-side bus seen by the bank mapper: address, write data and Z80 strobes.
interface zx_bank_mapper_if;
    logic [15:0] A;
    logic [7:0]  D;
    logic        nMREQ;
    logic        nIORQ;
    logic        nRD;
    logic        nWR;

    modport master (output A, D, nMREQ, nIORQ, nRD, nWR);
    modport slave  (input  A, D, nMREQ, nIORQ, nRD, nWR);
endinterface

// File: rtl/zx_io_strobe.sv
// Synchronises an asynchronous I/O write strobe into clock_25 and emits one
// single-cycle pulse per assertion; a strobe already high at reset release is ignored.
module zx_io_strobe (
    input  logic clock_25,
    input  logic RESET_N,
    input  logic strobe_raw,
    output logic io_pulse
);

    logic       sync1_reg;
    logic       sync2_reg;
    logic       prev_reg;
    logic       armed_reg;
    logic [1:0] fill_reg;

    // armed_reg only sets once the synchroniser has refilled after reset and shows
    // the strobe low, so a write that straddled reset cannot produce a late pulse.
    always_ff @(posedge clock_25) begin
        if (!RESET_N) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
            armed_reg <= 1'b0;
            fill_reg  <= 2'd0;
        end else begin
            sync1_reg <= strobe_raw;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            if (!fill_reg[1]) begin
                fill_reg <= fill_reg + 2'd1;
            end
            if (fill_reg[1] && !sync2_reg) begin
                armed_reg <= 1'b1;
            end
        end
    end

    assign io_pulse = sync2_reg && !prev_reg && armed_reg;

endmodule

// File: rtl/zx_bank_mapper.sv
// 128K/+3 style memory paging: decodes OUT writes to 7FFD/1FFD/FE and translates
// CPU addresses into physical RAM/ROM addresses combinationally.
module zx_bank_mapper
    import zx_pkg::*;
#(
    parameter int BANK_BITS   = 3,
    parameter int P3_EN       = 0,
    parameter int FULL_DECODE = 1,
    parameter int LOCK_EN     = 1
) (
    input  logic                      clock_25,
    input  logic                      RESET_N,
    zx_bank_mapper_if.slave           bus,
    output logic [14+BANK_BITS-1:0]   ram_addr,
    output logic [14+P3_EN:0]         rom_addr,
    output logic                      rom_sel,
    output logic                      ram_we,
    output logic                      screen_sel,
    output logic [2:0]                border,
    output logic                      beeper
);

    localparam bit LOCK_ACTIVE = (LOCK_EN != 0) && (BANK_BITS <= 5);
    localparam bit SPECIAL_EN  = (P3_EN != 0);
    localparam bit FULL        = (FULL_DECODE != 0);

    logic [7:0] p7ffd_reg;
    logic [2:0] p1ffd_reg;
    logic       lock_reg;
    logic [2:0] border_reg;
    logic       beeper_reg;

    logic io_wr_raw;
    logic io_pulse;
    logic io_write;
    logic hit_7ffd;
    logic hit_1ffd;
    logic hit_fe;

    assign io_wr_raw = !bus.nIORQ && !bus.nWR && bus.nRD;

    zx_io_strobe u_io_strobe (
        .clock_25   (clock_25),
        .RESET_N    (RESET_N),
        .strobe_raw (io_wr_raw),
        .io_pulse   (io_pulse)
    );

    // The pulse lags the bus by the synchroniser depth, so the strobe must still be
    // asserted when it arrives; a strobe that has already gone away is discarded.
    assign io_write = io_pulse && io_wr_raw;
    assign hit_7ffd = is_port_7ffd(bus.A, FULL);
    assign hit_1ffd = SPECIAL_EN && is_port_1ffd(bus.A, FULL);
    assign hit_fe   = is_port_fe(bus.A);

    always_ff @(posedge clock_25) begin
        if (!RESET_N) begin
            p7ffd_reg  <= 8'd0;
            p1ffd_reg  <= 3'd0;
            lock_reg   <= 1'b0;
            border_reg <= 3'd0;
            beeper_reg <= 1'b0;
        end else if (io_write) begin
            if (hit_7ffd && !lock_reg) begin
                p7ffd_reg <= bus.D;
                if (LOCK_ACTIVE) begin
                    lock_reg <= bus.D[5];
                end
            end
            if (hit_1ffd && !lock_reg) begin
                p1ffd_reg <= bus.D[2:0];
            end
            if (hit_fe) begin
                border_reg <= bus.D[2:0];
                beeper_reg <= bus.D[4];
            end
        end
    end

    // Bank bit order is {7FFD[5], 7FFD[7:6], 7FFD[2:0]}; bit 5 is the lock when locking is active.
    logic [5:0]           sel_bank_full;
    logic [BANK_BITS-1:0] sel_bank;
    logic                 special_mode;
    logic [1:0]           slot;
    logic [BANK_BITS-1:0] bank;
    logic                 rom_hit;

    assign sel_bank_full = {(LOCK_ACTIVE ? 1'b0 : p7ffd_reg[5]), p7ffd_reg[7:6], p7ffd_reg[2:0]};
    assign sel_bank      = sel_bank_full[BANK_BITS-1:0];
    assign special_mode  = SPECIAL_EN && p1ffd_reg[0];
    assign slot          = bus.A[15:14];

    always_comb begin
        bank    = '0;
        rom_hit = 1'b0;
        if (special_mode) begin
            bank = BANK_BITS'(special_bank(special_map_t'(p1ffd_reg[2:1]), slot));
        end else begin
            case (slot)
                2'd0:    rom_hit = 1'b1;
                2'd1:    bank = BANK_BITS'(BANK_SCREEN);
                2'd2:    bank = BANK_BITS'(BANK_FIXED);
                default: bank = sel_bank;
            endcase
        end
    end

    assign ram_addr = {bank, bus.A[13:0]};
    assign rom_sel  = rom_hit;
    assign ram_we   = !bus.nMREQ && !bus.nWR && !rom_hit;

    generate
        if (SPECIAL_EN) begin : g_rom_p3
            assign rom_addr = {p1ffd_reg[2], p7ffd_reg[4], bus.A[13:0]};
        end else begin : g_rom_128
            assign rom_addr = {p7ffd_reg[4], bus.A[13:0]};
        end
    endgenerate

    assign screen_sel = p7ffd_reg[3];
    assign border     = border_reg;
    assign beeper     = beeper_reg;

    // Register bits that some parameter sets leave without a reader.
    logic unused_bits;
    assign unused_bits = ^{sel_bank_full, p1ffd_reg};

endmodule

// File: tb/tb_zx_bank_mapper.sv
// Scoreboard bench for two mapper configurations (128K full-decode with lock, and
// 512K +3 partial-decode without lock) driven from one shared CPU bus.
module tb_zx_bank_mapper;

    logic clock_25 = 1'b0;
    logic RESET_N  = 1'b0;
    always #20 clock_25 = ~clock_25;

    zx_bank_mapper_if bus();

    logic [16:0] ram_addr_a;
    logic [14:0] rom_addr_a;
    logic        rom_sel_a, ram_we_a, screen_sel_a, beeper_a;
    logic [2:0]  border_a;
    logic [18:0] ram_addr_b;
    logic [15:0] rom_addr_b;
    logic        rom_sel_b, ram_we_b, screen_sel_b, beeper_b;
    logic [2:0]  border_b;

    zx_bank_mapper #(.BANK_BITS(3), .P3_EN(0), .FULL_DECODE(1), .LOCK_EN(1)) dut_a (
        .clock_25(clock_25), .RESET_N(RESET_N), .bus(bus),
        .ram_addr(ram_addr_a), .rom_addr(rom_addr_a), .rom_sel(rom_sel_a),
        .ram_we(ram_we_a), .screen_sel(screen_sel_a), .border(border_a), .beeper(beeper_a)
    );

    zx_bank_mapper #(.BANK_BITS(5), .P3_EN(1), .FULL_DECODE(0), .LOCK_EN(0)) dut_b (
        .clock_25(clock_25), .RESET_N(RESET_N), .bus(bus),
        .ram_addr(ram_addr_b), .rom_addr(rom_addr_b), .rom_sel(rom_sel_b),
        .ram_we(ram_we_b), .screen_sel(screen_sel_b), .border(border_b), .beeper(beeper_b)
    );

    typedef struct {
        logic [18:0] ram;
        logic [15:0] rom;
        logic        rom_sel;
        logic        we;
        logic        scr;
        logic [2:0]  border;
        logic        beep;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks   = 0;
    int   failures = 0;
    int   pulse_cnt = 0;
    int   exp_pulses = 0;
    logic chk_req = 1'b0;

    // Reference state per configuration: index 0 = dut_a, 1 = dut_b.
    int r7[2], r1[2], lk[2], bd[2], bp[2];
    int spec_tbl[4][4] = '{'{0,1,2,3}, '{4,5,6,7}, '{4,5,6,3}, '{4,7,6,3}};

    function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            r7[c] = 0; r1[c] = 0; lk[c] = 0; bd[c] = 0; bp[c] = 0;
        end
    endfunction

    function automatic void model_write(input int addr, input int data);
        int a1;
        a1 = (addr >> 1) & 1;
        if (addr == 'h7FFD && lk[0] == 0) begin
            r7[0] = data;
            lk[0] = (data >> 5) & 1;
        end
        if (addr < 'h8000 && a1 == 0) r7[1] = data;
        if ((addr >> 12) == 1 && a1 == 0) r1[1] = data;
        if ((addr & 1) == 0) begin
            for (int c = 0; c < 2; c++) begin
                bd[c] = data & 7;
                bp[c] = (data >> 4) & 1;
            end
        end
    endfunction

    function automatic exp_t model_read(input int c, input int addr, input bit memwr);
        exp_t e;
        int slot, off, bank;
        bit rom;
        slot = addr >> 14;
        off  = addr & 'h3FFF;
        bank = 0;
        rom  = 0;
        if (c == 1 && (r1[1] & 1) != 0) begin
            bank = spec_tbl[(r1[1] >> 1) & 3][slot];
        end else if (slot == 0) rom = 1;
        else if (slot == 1) bank = 5;
        else if (slot == 2) bank = 2;
        else if (c == 0) bank = r7[0] & 7;
        else bank = (r7[1] & 7) + ((r7[1] >> 6) & 3) * 8;
        e.ram = 19'(bank * 16384 + off);
        if (c == 0) e.rom = 16'(((r7[0] >> 4) & 1) * 16384 + off);
        else e.rom = 16'(((r1[1] >> 2) & 1) * 32768 + ((r7[1] >> 4) & 1) * 16384 + off);
        e.rom_sel = rom;
        e.we      = memwr && !rom;
        e.scr     = 1'((r7[c] >> 3) & 1);
        e.border  = 3'(bd[c]);
        e.beep    = 1'(bp[c]);
        return e;
    endfunction

    // Monitor: one sample per requested probe, half a cycle after inputs settle.
    always @(negedge clock_25) begin
        if (chk_req) begin
            exp_t ea, eb;
            if (qa.size() == 0 || qb.size() == 0) begin
                cmp("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                ea = qa.pop_front();
                eb = qb.pop_front();
                if (!ea.rom_sel) cmp("a.ram_addr", 32'(ram_addr_a), 32'(ea.ram));
                cmp("a.rom_addr", 32'(rom_addr_a), 32'(ea.rom));
                cmp("a.rom_sel", 32'(rom_sel_a), 32'(ea.rom_sel));
                cmp("a.ram_we", 32'(ram_we_a), 32'(ea.we));
                cmp("a.screen_sel", 32'(screen_sel_a), 32'(ea.scr));
                cmp("a.border", 32'(border_a), 32'(ea.border));
                cmp("a.beeper", 32'(beeper_a), 32'(ea.beep));
                if (!eb.rom_sel) cmp("b.ram_addr", 32'(ram_addr_b), 32'(eb.ram));
                cmp("b.rom_addr", 32'(rom_addr_b), 32'(eb.rom));
                cmp("b.rom_sel", 32'(rom_sel_b), 32'(eb.rom_sel));
                cmp("b.ram_we", 32'(ram_we_b), 32'(eb.we));
                cmp("b.screen_sel", 32'(screen_sel_b), 32'(eb.scr));
                cmp("b.border", 32'(border_b), 32'(eb.border));
                cmp("b.beeper", 32'(beeper_b), 32'(eb.beep));
            end
        end
    end

    always @(posedge clock_25) begin
        if (dut_a.io_pulse) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic probe(input int addr, input bit memwr);
        @(posedge clock_25); #1;
        bus.A = 16'(addr);
        if (memwr) begin
            bus.nMREQ = 1'b0;
            bus.nWR   = 1'b0;
        end
        qa.push_back(model_read(0, addr, memwr));
        qb.push_back(model_read(1, addr, memwr));
        chk_req = 1'b1;
        @(posedge clock_25); #1;
        chk_req = 1'b0;
        if (memwr) begin
            bus.nMREQ = 1'b1;
            bus.nWR   = 1'b1;
        end
    endtask

    task automatic io_write(input int addr, input int data, input int hold);
        @(posedge clock_25); #1;
        bus.A = 16'(addr);
        bus.D = 8'(data);
        bus.nIORQ = 1'b0;
        bus.nWR   = 1'b0;
        repeat (hold) @(posedge clock_25);
        #1;
        bus.nIORQ = 1'b1;
        bus.nWR   = 1'b1;
        if (hold >= 3) model_write(addr, data);
        exp_pulses++;
        repeat (3) @(posedge clock_25);
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clock_25); #1;
        RESET_N = 1'b0;
        model_reset();
        repeat (cycles) @(posedge clock_25);
        #1;
        RESET_N = 1'b1;
        repeat (3) @(posedge clock_25);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0, addr, data, op;
        int addr_list[6] = '{'h7FFD, 'h1FFD, 'h00FE, 'h7FFC, 'h1FFC, 'h3FFD};
        bus.A = 16'h0000; bus.D = 8'h00;
        bus.nMREQ = 1'b1; bus.nIORQ = 1'b1; bus.nRD = 1'b1; bus.nWR = 1'b1;
        model_reset();
        do_reset(4);

        probe('h0123, 1'b0);
        cmp("reset_rom_sel", 32'(rom_sel_a), 32'd1);
        cmp("reset_rom_addr", 32'(rom_addr_a), 32'h0123);
        cmp("reset_screen_sel", 32'(screen_sel_a), 32'd0);

        // Update latency of an OUT to 7FFD, watched through the ROM high bit.
        @(posedge clock_25); #1;
        bus.A = 16'h7FFD; bus.D = 8'h17; bus.nIORQ = 1'b0; bus.nWR = 1'b0;
        repeat (2) @(posedge clock_25);
        #1 cmp("latency_before", 32'(rom_addr_a[14]), 32'd0);
        repeat (2) @(posedge clock_25);
        #1 cmp("latency_after", 32'(rom_addr_a[14]), 32'd1);
        bus.nIORQ = 1'b1; bus.nWR = 1'b1;
        model_write('h7FFD, 'h17);
        exp_pulses++;
        repeat (3) @(posedge clock_25);
        probe('hC010, 1'b0);
        cmp("bank7_ram_addr", 32'(ram_addr_a), 32'h1C010);
        cmp("bank7_screen_sel", 32'(screen_sel_a), 32'd0);

        // Lock holds off further paging until reset.
        io_write('h7FFD, 'h20, 5);
        io_write('h7FFD, 'h03, 5);
        probe('hC000, 1'b0);
        cmp("locked_bank", 32'(ram_addr_a[16:14]), 32'd0);
        do_reset(2);
        io_write('h7FFD, 'h03, 5);
        probe('hC000, 1'b0);
        cmp("unlocked_bank", 32'(ram_addr_a[16:14]), 32'd3);

        do_reset(2);
        io_write('h7FFD, 'hC6, 6);
        probe('hC000, 1'b0);
        cmp("bank30", 32'(ram_addr_b[18:14]), 32'd30);

        io_write('h1FFD, 'h07, 6);
        probe('h0000, 1'b1);
        cmp("special_rom_sel", 32'(rom_sel_b), 32'd0);
        cmp("special_bank", 32'(ram_addr_b[18:14]), 32'd4);

        p0 = pulse_cnt;
        io_write('h00FE, 'h15, 20);
        probe('h4000, 1'b0);
        cmp("fe_border", 32'(border_a), 32'd5);
        cmp("fe_beeper", 32'(beeper_a), 32'd1);
        cmp("fe_one_pulse", 32'(pulse_cnt - p0), 32'd1);

        io_write('h00FE, 'h02, 1);
        probe('h8000, 1'b0);
        io_write('h7FFC, 'h0B, 5);
        probe('hC123, 1'b0);

        // A write straddling reset release must never land.
        @(posedge clock_25); #1;
        RESET_N = 1'b0;
        model_reset();
        bus.A = 16'h00FE; bus.D = 8'h07; bus.nIORQ = 1'b0; bus.nWR = 1'b0;
        p0 = pulse_cnt;
        repeat (3) @(posedge clock_25);
        #1 RESET_N = 1'b1;
        repeat (6) @(posedge clock_25);
        probe('h00FE, 1'b0);
        cmp("straddle_no_pulse", 32'(pulse_cnt - p0), 32'd0);
        #1 bus.nIORQ = 1'b1; bus.nWR = 1'b1;
        repeat (3) @(posedge clock_25);
        io_write('h00FE, 'h07, 5);
        probe('h00FE, 1'b0);

        for (int i = 0; i < 150; i++) begin
            op = $urandom_range(0, 39);
            if (op == 0) begin
                do_reset($urandom_range(1, 3));
            end else if (op < 20) begin
                addr = (op < 16) ? addr_list[$urandom_range(0, 5)] : int'($urandom_range(0, 65535));
                data = $urandom_range(0, 255);
                io_write(addr, data, $urandom_range(1, 8));
            end else begin
                probe($urandom_range(0, 65535), 1'($urandom_range(0, 1)));
            end
        end

        repeat (2) @(posedge clock_25);
        cmp("pulse_total", 32'(pulse_cnt), 32'(exp_pulses));
        cmp("scoreboard_drained", 32'(qa.size() + qb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
